// File: rtl/umi_pack_tx.sv
// UMI transmit packer: builds the 256-bit UMI packet from discrete fields and
// streams it out low beat first as UW/OW beats over a valid/ready link.
module umi_pack_tx #(
  parameter int AW = 64,
  parameter int UW = 256,
  parameter int OW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_write,
  input  logic [7:0]    in_command,
  input  logic [3:0]    in_size,
  input  logic [19:0]   in_options,
  input  logic [AW-1:0] in_dstaddr,
  input  logic [AW-1:0] in_srcaddr,
  input  logic [63:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_packet,
  output logic          out_first,
  output logic          out_last
);

  localparam int N  = UW / OW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [UW-1:0] shift;
  logic          load;
  logic          advance;
  logic          unused_cmd0;

  // in_write replaces the opcode's low bit, so in_command[0] is never read.
  assign unused_cmd0 = in_command[0];

  function automatic logic [UW-1:0] pack(
    input logic          write,
    input logic [6:0]    command_hi,
    input logic [3:0]    size,
    input logic [19:0]   options,
    input logic [AW-1:0] dstaddr,
    input logic [AW-1:0] srcaddr,
    input logic [63:0]   data
  );
    logic [63:0] dst;
    logic [63:0] src;
    dst = 64'(dstaddr);
    src = 64'(srcaddr);
    return UW'({32'h0, src[63:32], dst[63:32], data[63:32], data[31:0],
                src[31:0], dst[31:0], options, size, command_hi, write});
  endfunction

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt == LAST) begin
            // Last beat leaving: a waiting bundle loads with no idle bubble.
            in_ready = 1'b1;
            if (in_valid) load = 1'b1;
            else          state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      shift <= '0;
    end else if (load) begin
      cnt   <= '0;
      shift <= pack(in_write, in_command[7:1], in_size, in_options,
                    in_dstaddr, in_srcaddr, in_data);
    end else if (advance) begin
      cnt   <= cnt + 1'b1;
      shift <= shift >> OW;
    end
  end

  assign out_valid  = (state == SEND);
  assign out_packet = shift[OW-1:0];
  assign out_first  = out_valid && (cnt == '0);
  assign out_last   = out_valid && (cnt == LAST);

endmodule

// File: tb/tb_umi_pack_tx.sv
// Scoreboard bench for umi_pack_tx: a multi-beat instance (OW=64) and a
// single-beat instance (AW=32, OW=UW=256), both against a field-level model.
module tb_umi_pack_tx;
  localparam int UW  = 256;
  localparam int OW0 = 64;
  localparam int N0  = UW / OW0;
  localparam int AW1 = 32;
  localparam int CKW = UW + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic           iv0, ir0, w0, ov0, rdy0, of0, ol0;
  logic [7:0]     c0;
  logic [3:0]     s0;
  logic [19:0]    o0;
  logic [63:0]    d0, sa0, dt0;
  logic [OW0-1:0] op0;

  logic           iv1, ir1, w1, ov1, rdy1, of1, ol1;
  logic [7:0]     c1;
  logic [3:0]     s1;
  logic [19:0]    o1;
  logic [AW1-1:0] d1, sa1;
  logic [63:0]    dt1;
  logic [UW-1:0]  op1;

  umi_pack_tx #(.AW(64), .UW(UW), .OW(OW0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_write(w0),
    .in_command(c0), .in_size(s0), .in_options(o0), .in_dstaddr(d0),
    .in_srcaddr(sa0), .in_data(dt0), .out_valid(ov0), .out_ready(rdy0),
    .out_packet(op0), .out_first(of0), .out_last(ol0));

  umi_pack_tx #(.AW(AW1), .UW(UW), .OW(UW)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_write(w1),
    .in_command(c1), .in_size(s1), .in_options(o1), .in_dstaddr(d1),
    .in_srcaddr(sa1), .in_data(dt1), .out_valid(ov1), .out_ready(rdy1),
    .out_packet(op1), .out_first(of1), .out_last(ol1));

  typedef struct packed {
    logic [UW-1:0] p;
    logic          f;
    logic          l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0, hs0 = 0, hs1 = 0, acc0_cyc = 0, pop0_cyc = 0, acc1 = 0;
  logic [UW-1:0] pk0;

  task automatic check(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packet assembled field by field from the layout table.
  function automatic logic [UW-1:0] ref_pack(input logic w, input logic [7:0] c,
      input logic [3:0] s, input logic [19:0] o, input logic [63:0] d,
      input logic [63:0] sa, input logic [63:0] dt);
    logic [UW-1:0] p;
    p = '0;
    p[7:0]     = c;
    p[0]       = w;
    p[11:8]    = s;
    p[31:12]   = o;
    p[63:32]   = d[31:0];
    p[95:64]   = sa[31:0];
    p[127:96]  = dt[31:0];
    p[159:128] = dt[63:32];
    p[191:160] = d[63:32];
    p[223:192] = sa[63:32];
    return p;
  endfunction

  initial begin : mon0
    beat_t e0;
    logic st0;
    logic [OW0+2:0] held0;
    st0 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q0.delete();
        st0 = 1'b0;
      end else begin
        if (st0) check("hold0", CKW'({ov0, op0, of0, ol0}), CKW'(held0));
        st0   = ov0 && !rdy0;
        held0 = {ov0, op0, of0, ol0};
        if (ov0 && rdy0) begin
          hs0++;
          pop0_cyc = cyc;
          check("beat_available0", CKW'(q0.size() > 0), CKW'(1));
          if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check("beat0", CKW'({op0, of0, ol0}), CKW'({e0.p[OW0-1:0], e0.f, e0.l}));
          end
        end
        if (iv0 && ir0) begin
          if (ov0) check("accept_on_last0", CKW'({ol0, rdy0}), CKW'(2'b11));
          acc0_cyc = cyc;
          pk0 = ref_pack(w0, c0, s0, o0, d0, sa0, dt0);
          for (int i = 0; i < N0; i++)
            q0.push_back(beat_t'{UW'(pk0[i*OW0 +: OW0]), (i == 0), (i == N0 - 1)});
        end
      end
    end
  end

  initial begin : mon1
    beat_t e1;
    logic st1;
    logic [UW+2:0] held1;
    st1 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q1.delete();
        st1 = 1'b0;
      end else begin
        if (st1) check("hold1", CKW'({ov1, op1, of1, ol1}), CKW'(held1));
        st1   = ov1 && !rdy1;
        held1 = {ov1, op1, of1, ol1};
        if (ov1 && rdy1) begin
          hs1++;
          check("beat_available1", CKW'(q1.size() > 0), CKW'(1));
          if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check("beat1", CKW'({op1, of1, ol1}), CKW'({e1.p, e1.f, e1.l}));
          end
        end
        if (iv1 && ir1) begin
          if (ov1) check("accept_on_last1", CKW'({ol1, rdy1}), CKW'(2'b11));
          acc1++;
          q1.push_back(beat_t'{ref_pack(w1, c1, s1, o1, 64'(d1), 64'(sa1), dt1), 1'b1, 1'b1});
        end
      end
    end
  end

  task automatic send0(input logic w, input logic [7:0] c, input logic [3:0] s,
      input logic [19:0] o, input logic [63:0] d, input logic [63:0] sa, input logic [63:0] dt);
    logic took;
    int n;
    w0 = w; c0 = c; s0 = s; o0 = o; d0 = d; sa0 = sa; dt0 = dt;
    iv0 = 1'b1;
    took = 1'b0;
    n = 0;
    while (!took && n < 300) begin
      @(negedge clk);
      took = ir0;
      n++;
      @(posedge clk);
      #1;
    end
    check("accept0", CKW'(took), CKW'(1));
    iv0 = 1'b0;
    w0 = 1'($urandom); c0 = 8'($urandom); d0 = {$urandom, $urandom}; dt0 = {$urandom, $urandom};
  endtask

  task automatic send1(input logic w, input logic [7:0] c, input logic [3:0] s,
      input logic [19:0] o, input logic [31:0] d, input logic [31:0] sa, input logic [63:0] dt);
    logic took;
    int n;
    w1 = w; c1 = c; s1 = s; o1 = o; d1 = d; sa1 = sa; dt1 = dt;
    iv1 = 1'b1;
    took = 1'b0;
    n = 0;
    while (!took && n < 300) begin
      @(negedge clk);
      took = ir1;
      n++;
      @(posedge clk);
      #1;
    end
    check("accept1", CKW'(took), CKW'(1));
    iv1 = 1'b0;
    w1 = 1'($urandom); c1 = 8'($urandom); d1 = $urandom; dt1 = {$urandom, $urandom};
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain0", CKW'(q0.size()), CKW'(0));
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain1", CKW'(q1.size()), CKW'(0));
  endtask

  task automatic send0_rand();
    send0(1'($urandom), 8'($urandom), 4'($urandom), 20'($urandom), {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic send1_rand();
    send1(1'($urandom), 8'($urandom), 4'($urandom), 20'($urandom), $urandom, $urandom,
          {$urandom, $urandom});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit pat [0:6];
    int a, h, busy;
    longint st;
    reset = 1'b1;
    iv0 = 0; w0 = 0; c0 = 0; s0 = 0; o0 = 0; d0 = 0; sa0 = 0; dt0 = 0; rdy0 = 0;
    iv1 = 0; w1 = 0; c1 = 0; s1 = 0; o1 = 0; d1 = 0; sa1 = 0; dt1 = 0; rdy1 = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_out0", CKW'({ov0, op0, of0, ol0}), CKW'(0));
    check("reset_out1", CKW'({ov1, op1, of1, ol1}), CKW'(0));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle0", CKW'({ov0, ir0, op0}), CKW'({1'b0, 1'b1, 64'h0}));
    end
    @(posedge clk);
    #1;

    // Directed single packet, beat 0 the cycle after acceptance
    rdy0 = 1'b1;
    send0(1'b1, 8'h02, 4'h3, 20'h12345, 64'h1_2345_6780, 64'h0000_0000_AABB_CC00,
          64'hDEAD_BEEF_0BAD_F00D);
    check("latency0", CKW'({ov0, of0}), CKW'(2'b11));
    check("beat0_value", CKW'(op0), CKW'(64'h2345_6780_1234_5303));
    drain0();

    // Backpressure
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    send0(1'b1, 8'h02, 4'h3, 20'h12345, 64'h1_2345_6780, 64'h0000_0000_AABB_CC00,
          64'hDEAD_BEEF_0BAD_F00D);
    h = hs0;
    for (int i = 0; i < 7; i++) begin
      rdy0 = pat[i];
      @(posedge clk);
      #1;
    end
    rdy0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_handshakes", CKW'(hs0 - h), CKW'(4));
    check("bp_idle", CKW'({ov0, q0.size() == 0}), CKW'(2'b01));

    // Back-to-back with in_valid held
    rdy0 = 1'b1;
    send0_rand();
    a = acc0_cyc;
    send0_rand();
    drain0();
    check("b2b_gapless0", CKW'(pop0_cyc - a), CKW'(8));

    // Reset while beat 2 is on the link
    send0_rand();
    repeat (2) begin @(posedge clk); #1; end
    #1 reset = 1'b1;
    #1 check("reset_async0", CKW'({ov0, op0, of0, ol0}), CKW'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    send0(1'b0, 8'h05, 4'h1, 20'hFEDCB, 64'h8000_0000_0000_0004, 64'h1234_5678_9ABC_DEF0,
          64'h0123_4567_89AB_CDEF);
    check("after_reset_first", CKW'({ov0, of0}), CKW'(2'b11));
    drain0();

    // Randomized traffic with random backpressure
    busy = 1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send0_rand();
        end
        busy = 0;
      end
      begin
        while (busy != 0) begin
          rdy0 = 1'($urandom);
          @(posedge clk);
          #1;
        end
      end
    join
    rdy0 = 1'b1;
    drain0();

    // Single-beat instance with AW=32: zero extension of the addresses
    rdy1 = 1'b1;
    send1(1'b1, 8'h04, 4'h2, 20'hABCDE, 32'hFFFF_0000, 32'h8000_0001, 64'h1111_2222_3333_4444);
    check("no_sign_ext_dst", CKW'(op1[191:160]), CKW'(0));
    check("no_sign_ext_src", CKW'(op1[223:192]), CKW'(0));
    check("dst_lo", CKW'(op1[63:32]), CKW'(32'hFFFF_0000));
    check("single_flags", CKW'({ov1, of1, ol1}), CKW'(3'b111));
    drain1();

    // One packet per cycle in single-beat mode
    h = hs1;
    st = $time;
    for (int k = 0; k < 6; k++) send1_rand();
    check("b2b_single_cycles", CKW'(($time - st) / 10), CKW'(6));
    drain1();
    check("b2b_single_beats", CKW'(hs1 - h), CKW'(6));

    busy = 1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send1_rand();
        end
        busy = 0;
      end
      begin
        while (busy != 0) begin
          rdy1 = 1'($urandom);
          @(posedge clk);
          #1;
        end
      end
    join
    rdy1 = 1'b1;
    drain1();

    repeat (3) begin @(posedge clk); #1; end
    check("final_idle", CKW'({ov0, ov1, q0.size() == 0, q1.size() == 0}), CKW'(4'b0011));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
